pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It generalises the fixed fetch-to-decode register, and every stage boundary of the pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) can use it. Beyond hold and flush, it gives:
- full-throughput backpressure with a registered `in_ready`;
- an explicit stall input;
- an occupancy output;
- saturating stall and flush event counters for performance analysis.

## Interface

Parameters:
- `DATA_W`, 64, payload width (e.g. `{pc, instr}`).
- `NOP_VAL`, 0, value driven on `out_data` when empty, after reset and after flush.
- `CNT_W`, 16, width of the saturating event counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  payload valid toward downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload toward downstream.
- `stall`  in  1  hazard-unit hold; blocks the output transfer.
- `flush`  in  1  squash all held entries.
- `occupancy`  out  2  number of valid entries, 0..2.
- `stall_cnt`  out  CNT_W  cycles with held output.
- `flush_cnt`  out  CNT_W  flush cycles that discarded at least one entry.

## Operation

Storage is a main register (M: `m_valid`, `m_data`) and a skid register (S: `s_valid`, `s_data`). `out_valid = m_valid` and `out_data = m_data`.

Transfer conditions:
- Input transfer `IN_T = in_valid & in_ready`.
- Output transfer `OUT_T = m_valid & out_ready & ~stall`.

Next-state rules, evaluated in priority order:
1. **`!rst`**: `m_valid = s_valid = 0`; `m_data = s_data = NOP_VAL`; `in_ready = 1`; both counters = 0.
2. **`flush`**: same as rule 1, except the counters are untouched. An `IN_T` in the same cycle is discarded. Flush overrides `stall`. `flush_cnt` += 1 (saturating) if `m_valid | s_valid` before the flush.
3. **Otherwise**:
   - If `OUT_T` or `~m_valid`, then M is free:
     - If `s_valid`, then M ← S and S is cleared. If `IN_T` also fires, S ← `in_data`.
     - Else if `IN_T`, then M ← `in_data`.
     - Else `m_valid = 0` and `m_data = NOP_VAL`.
   - Else (M is held):
     - If `IN_T`, then S ← `in_data` with `s_valid = 1`. This is legal only when `s_valid = 0`, which `in_ready` guarantees.
   - `in_ready` next = `~s_valid` next.

Other rules:
- `occupancy = m_valid + s_valid`, combinational from registers.
- `stall_cnt` += 1 (saturating) on each cycle with `m_valid & (~out_ready | stall)` and no `flush`.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- Data ordering is strict FIFO: S is always younger than M.
- There is no combinational path from `out_ready` or `stall` to `in_ready`.
- Invariant: `s_valid` implies `m_valid`.

## Timing

- Latency: 1 cycle from `IN_T` to `out_valid`, when the stage is empty.
- Throughput: 1 transfer/cycle while `out_ready & ~stall` stays high.
- Hold behaviour:
  - The first held cycle absorbs one extra beat into S.
  - `in_ready` falls in the cycle after S fills.
  - It rises in the cycle after S drains into M.
- Release: M updates on the first cycle `stall` deasserts and `out_ready` is high.
- Reset: all outputs take their reset values in the cycle after the `clk` edge that samples `rst = 0`:
  - `out_valid` 0, `out_data` `NOP_VAL`, `in_ready` 1, `occupancy` 0, counters 0.
  - Reset mid-transfer drops both entries.
- Flush: takes effect at the next edge. `out_valid` is 0 the following cycle and `in_ready` is 1.
- Simultaneous `IN_T` and `OUT_T` with M full and S empty: M ← `in_data`, `occupancy` stays 1.
- Simultaneous `IN_T` and `OUT_T` with S full: cannot occur, because `in_ready` = 0.
- `stall` and `out_ready` = 0 are equivalent for data movement. Both increment `stall_cnt`.

## Test plan

- **Streaming:** `DATA_W` = 64, `out_ready` = 1, `stall` = 0, 8 back-to-back beats 0x1..0x8 → `out_data` 0x1..0x8 on consecutive cycles starting 1 cycle after the first beat; `occupancy` ≤ 1; `stall_cnt` = 0.
- **Backpressure skid:** stream 0xA, 0xB, 0xC and drop `out_ready` while 0xA is in M → 0xB enters S; `in_ready` = 0 the next cycle; 0xC is held upstream; raise `out_ready` → 0xA, 0xB, 0xC delivered in order with no loss or duplication; `stall_cnt` equals the held cycles.
- **Stall vs ready:** assert `stall` = 1 for 3 cycles with `out_ready` = 1 and M = 0x55 → `out_data` stays 0x55; `stall_cnt` = 3; 0x55 transfers on the first cycle after `stall` drops.
- **Flush:** with occupancy 2 and `in_valid` = 1, assert `flush` one cycle together with `stall` → next cycle `out_valid` = 0, `out_data` = `NOP_VAL`, `occupancy` = 0, `in_ready` = 1; the input beat is discarded; `flush_cnt` = 1. A flush on an empty stage leaves `flush_cnt` unchanged.
- **Reset mid-operation:** assert `rst` = 0 for one cycle with occupancy 2 → all outputs at their reset values the next cycle, counters = 0; normal streaming resumes the following cycle.
- **Counter saturation:** `CNT_W` = 4, hold `out_ready` = 0 with M valid for 20 cycles → `stall_cnt` = 15 and stays 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// stall/flush control, occupancy output and saturating perf counters.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W  = 64,
    parameter logic [DATA_W-1:0]    NOP_VAL = '0,
    parameter int unsigned          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;

    logic              m_valid_nxt, s_valid_nxt, in_ready_nxt;
    logic [DATA_W-1:0] m_data_nxt, s_data_nxt;
    logic [CNT_W-1:0]  stall_cnt_nxt, flush_cnt_nxt;

    logic in_t, out_t, held;

    assign in_t  = in_valid & in_ready;
    assign out_t = m_valid & out_ready & ~stall;
    assign held  = m_valid & (~out_ready | stall);

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    // Next-state for main/skid entries and event counters.
    always_comb begin
        m_valid_nxt   = m_valid;
        m_data_nxt    = m_data;
        s_valid_nxt   = s_valid;
        s_data_nxt    = s_data;
        stall_cnt_nxt = stall_cnt;
        flush_cnt_nxt = flush_cnt;

        if (flush) begin
            m_valid_nxt = 1'b0;
            m_data_nxt  = NOP_VAL;
            s_valid_nxt = 1'b0;
            s_data_nxt  = NOP_VAL;
            if ((m_valid | s_valid) && flush_cnt != CNT_MAX) begin
                flush_cnt_nxt = flush_cnt + CNT_W'(1);
            end
        end else begin
            if (out_t | ~m_valid) begin
                // Main entry is free: refill from skid first to keep FIFO order.
                if (s_valid) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = s_data;
                    s_valid_nxt = 1'b0;
                    s_data_nxt  = NOP_VAL;
                    if (in_t) begin
                        s_valid_nxt = 1'b1;
                        s_data_nxt  = in_data;
                    end
                end else if (in_t) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = in_data;
                end else begin
                    m_valid_nxt = 1'b0;
                    m_data_nxt  = NOP_VAL;
                end
            end else if (in_t) begin
                // Main entry held: absorb the in-flight beat into the skid.
                s_valid_nxt = 1'b1;
                s_data_nxt  = in_data;
            end
            if (held && stall_cnt != CNT_MAX) begin
                stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
        end

        in_ready_nxt = ~s_valid_nxt;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid   <= 1'b0;
            m_data    <= NOP_VAL;
            s_valid   <= 1'b0;
            s_data    <= NOP_VAL;
            in_ready  <= 1'b1;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            m_valid   <= m_valid_nxt;
            m_data    <= m_data_nxt;
            s_valid   <= s_valid_nxt;
            s_data    <= s_data_nxt;
            in_ready  <= in_ready_nxt;
            stall_cnt <= stall_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

endmodule
